// File: rtl/cb_fifo_mc.sv
// Multi-channel credit FIFO: NUM_CH circular queues behind one channel-tagged ingress,
// drained through one egress by a round-robin arbiter that locks its grant while stalled.
module cb_fifo_mc #(
    parameter  int Data_W   = 32,
    parameter  int DEPTH    = 8,
    parameter  int NUM_CH   = 4,
    parameter  int AFULL_TH = 6,
    localparam int LW       = $clog2(DEPTH + 1),
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CW-1:0]        s_ch,
    input  logic [Data_W-1:0]    s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        m_ch,
    output logic [Data_W-1:0]    m_data,
    output logic [NUM_CH*LW-1:0] level,
    output logic [NUM_CH-1:0]    empty,
    output logic [NUM_CH-1:0]    full,
    output logic [NUM_CH-1:0]    afull,
    output logic [NUM_CH*LW-1:0] credits,
    output logic [NUM_CH-1:0]    credit_ret
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [Data_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [LW-1:0]     lvl    [NUM_CH];

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     lock_ch;
    logic [CW-1:0]     gnt;
    logic              locked;
    logic              any_ne;
    logic              ch_ok;
    logic              push;
    logic              pop;
    logic [NUM_CH-1:0] push_vec;
    logic [NUM_CH-1:0] pop_vec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = lock_ch;
        any_ne = locked;
        if (!locked) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (lvl[idx] != '0) begin
                    gnt    = CW'(idx);
                    any_ne = 1'b1;
                end
            end
        end
    end

    assign ch_ok = (int'(s_ch) < NUM_CH);

    always_comb begin
        s_ready = 1'b0;
        if (rst_n && ch_ok) s_ready = (lvl[s_ch] != LW'(DEPTH));
    end

    assign m_valid = any_ne;
    assign m_ch    = gnt;
    assign m_data  = mem[gnt][rd_ptr[gnt]];
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            push_vec[c] = push && (int'(s_ch) == c);
            pop_vec[c]  = pop && (int'(gnt) == c);
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_vec[c]) mem[c][wr_ptr[c]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                lvl[c]    <= '0;
            end
            rr_ptr     <= '0;
            lock_ch    <= '0;
            locked     <= 1'b0;
            credit_ret <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_vec[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop_vec[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                if (push_vec[c] && !pop_vec[c])      lvl[c] <= lvl[c] + 1'b1;
                else if (pop_vec[c] && !push_vec[c]) lvl[c] <= lvl[c] - 1'b1;
            end
            credit_ret <= pop_vec;
            // A stalled grant stays frozen so m_ch/m_data cannot change under the sink.
            if (pop) begin
                locked <= 1'b0;
                rr_ptr <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
            end else if (m_valid) begin
                locked  <= 1'b1;
                lock_ch <= gnt;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            level[c*LW +: LW]   = lvl[c];
            credits[c*LW +: LW] = LW'(DEPTH) - lvl[c];
            empty[c]            = (lvl[c] == '0);
            full[c]             = (lvl[c] == LW'(DEPTH));
            afull[c]            = (lvl[c] >= LW'(AFULL_TH));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lvl_chk
        assert property (@(posedge clk) disable iff (!rst_n) lvl[c] <= LW'(DEPTH));
    end

endmodule

// File: tb/tb_cb_fifo_mc.sv
// Bench for cb_fifo_mc: directed scenarios plus random traffic, all checked against
// a queue-based model of the channels and the round-robin/lock arbitration rules.
module tb_cb_fifo_mc;

    localparam int NCH = 4;
    localparam int DEP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_ch;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_ch;
    logic [31:0] m_data;
    logic [15:0] level;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  afull;
    logic [15:0] credits;
    logic [3:0]  credit_ret;

    cb_fifo_mc #(.Data_W(32), .DEPTH(DEP), .NUM_CH(NCH), .AFULL_TH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_data(m_data),
        .level(level), .empty(empty), .full(full), .afull(afull),
        .credits(credits), .credit_ret(credit_ret)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] q [NCH][$];
    int          rr;
    bit          lk;
    int          lk_ch;
    logic [3:0]  exp_cr;
    logic [3:0]  cov_full  = '0;
    logic [3:0]  cov_empty = '0;
    logic [3:0]  cov_pp    = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) q[c].delete();
        rr     = 0;
        lk     = 1'b0;
        lk_ch  = 0;
        exp_cr = '0;
    endtask

    // Drives one cycle of stimulus, checks outputs at the negedge, advances the model at the posedge.
    task automatic cycle(input bit sv, input int ch, input logic [31:0] d, input bit mr);
        int         g;
        bit         v;
        bit         rdy;
        bit         pu;
        bit         po;
        logic [3:0] ee;
        logic [3:0] ef;
        logic [3:0] ea;
        s_valid = sv;
        s_ch    = 2'(ch);
        s_data  = d;
        m_ready = mr;
        @(negedge clk);
        v = 1'b0;
        g = 0;
        if (lk) begin
            v = 1'b1;
            g = lk_ch;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (rr + i) % NCH;
                if (!v && q[c].size() > 0) begin
                    v = 1'b1;
                    g = c;
                end
            end
        end
        rdy = (q[ch].size() < DEP);
        chk("m_valid", 64'(m_valid), 64'(v));
        if (v) begin
            chk("m_ch", 64'(m_ch), 64'(g));
            chk("m_data", 64'(m_data), 64'(q[g][0]));
        end
        chk("s_ready", 64'(s_ready), 64'(rdy));
        for (int c = 0; c < NCH; c++) begin
            chk("level", 64'(level[c*4 +: 4]), 64'(q[c].size()));
            chk("credits", 64'(credits[c*4 +: 4]), 64'(DEP - q[c].size()));
            ee[c] = (q[c].size() == 0);
            ef[c] = (q[c].size() == DEP);
            ea[c] = (q[c].size() >= 6);
        end
        chk("empty", 64'(empty), 64'(ee));
        chk("full", 64'(full), 64'(ef));
        chk("afull", 64'(afull), 64'(ea));
        chk("credit_ret", 64'(credit_ret), 64'(exp_cr));
        pu = sv && rdy;
        po = v && mr;
        @(posedge clk);
        if (pu) q[ch].push_back(d);
        if (po) begin
            void'(q[g].pop_front());
            rr = (g + 1) % NCH;
            lk = 1'b0;
        end else if (v) begin
            lk    = 1'b1;
            lk_ch = g;
        end
        exp_cr = po ? 4'(1 << g) : 4'b0;
        for (int c = 0; c < NCH; c++) begin
            if (q[c].size() == DEP) cov_full[c] = 1'b1;
            if (q[c].size() == 0 && ch == c && !pu) cov_empty[c] = 1'b1;
        end
        if (pu && po && ch == g) cov_pp[ch] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_ch    = '0;
        s_data  = '0;
        rst_n   = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_s_ready", 64'(s_ready), 64'h0);
        chk("rst_empty", 64'(empty), 64'hF);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_afull", 64'(afull), 64'h0);
        chk("rst_credits", 64'(credits), 64'h8888);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_credit_ret", 64'(credit_ret), 64'h0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit sv;
        bit mr;
        int ph;
        rst_n = 1'b1;
        #2;
        // T1
        do_reset();
        cycle(0, 0, 32'h0, 0);

        // T2
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 32'hA5A5_0000 + 32'(i), 0);
            if (i == 5) begin
                chk("t2_afull_at6", 64'(afull[0]), 64'h1);
                chk("t2_notfull_at6", 64'(full[0]), 64'h0);
            end
        end
        chk("t2_full0", 64'(full[0]), 64'h1);
        chk("t2_credits0", 64'(credits[3:0]), 64'h0);
        cycle(1, 0, 32'hDEAD_0000, 0);
        cycle(1, 1, 32'hBEEF_0001, 0);

        // T3
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 2; k++) cycle(1, c, 32'h3000_0000 + 32'(c * 16 + k), 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 32'h0, 1);

        // T4
        cycle(1, 2, 32'h4444_0002, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'h4000_0000 + 32'(i), 0);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 0);

        // T5
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h5000_0000 + 32'(i), 0);
        cycle(1, 1, 32'h5000_0003, 1);
        chk("t5_level_pp", 64'(level[7:4]), 64'h3);
        cycle(0, 1, 32'h0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h5100_0000 + 32'(i), 0);
        chk("t5_full1", 64'(full[1]), 64'h1);
        cycle(1, 1, 32'h5FFF_FFFF, 1);
        chk("t5_level_fullpp", 64'(level[7:4]), 64'h7);
        cycle(0, 1, 32'h0, 0);

        // T6
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            ph = i % 1000;
            if (ph < 300) begin
                sv = ($urandom % 8) != 0;
                mr = ($urandom % 8) == 0;
            end else if (ph < 700) begin
                sv = ($urandom % 4) == 0;
                mr = ($urandom % 8) != 0;
            end else begin
                sv = $urandom % 2 == 1;
                mr = $urandom % 2 == 1;
            end
            cycle(sv, int'($urandom_range(0, NCH - 1)), $urandom, mr);
        end
        chk("cov_full", 64'(cov_full), 64'hF);
        chk("cov_empty", 64'(cov_empty), 64'hF);
        chk("cov_push_pop", 64'(cov_pp), 64'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
